// File: rtl/bus_pkg.sv
// Shared bus types for the SRAM slave: transfer type/size encodings (load/store
// funct3[1:0]), FSM state type and byte-lane helper functions.
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sram_state_e;

  // Byte lanes touched by an access; the unused encoding 3 behaves as WORD.
  function automatic logic [3:0] lane_mask(input tsize_e sz, input logic [1:0] lo);
    case (sz)
      BYTE:    lane_mask = 4'b0001 << lo;
      HALF:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input tsize_e sz, input logic [31:0] wd);
    case (sz)
      BYTE:    lane_wdata = {4{wd[7:0]}};
      HALF:    lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] lane_rdata(input tsize_e sz, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (sz)
      BYTE:    lane_rdata = {24'h0, shifted[7:0]};
      HALF:    lane_rdata = lo[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      default: lane_rdata = word;
    endcase
  endfunction

  function automatic logic misaligned(input tsize_e sz, input logic [1:0] lo);
    case (sz)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH_WORDS x 32 storage with a byte-enable write port and a registered
// (synchronous) read port sharing one word address.
module sram_byte_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: storage and its read register have no reset; clearing a RAM would
  // need a multi-cycle sweep, and the owner masks rdata until a read completes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_slave.sv
// Single-port SRAM bus slave with programmable wait states.
// Define SRAM_SLAVE_ERR_EN to add the berr port and misalignment checking.
module sram_slave
  import bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bstart,
  input  ttype_e      ttype,
  input  tsize_e      tsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone
`ifdef SRAM_SLAVE_ERR_EN
  ,
  output logic        berr
`endif
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  sram_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  ttype_e        ttype_q;
  tsize_e        tsize_q;
  logic [1:0]    lo_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic [31:0]   offset;
  logic          in_range;
  logic          live_err;

  ttype_e        req_ttype;
  tsize_e        req_tsize;
  logic [1:0]    req_lo;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_wdata;

  logic          enter_resp;
  logic          mem_we;
  logic          mem_re;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   rd_fmt;

  // Decode of the live request; BASE_ADDR alignment makes the offset a word index.
  always_comb begin
    offset   = addr - BASE_ADDR;
    in_range = ((offset >> (AW + 2)) == 32'd0);
`ifdef SRAM_SLAVE_ERR_EN
    live_err = !in_range || misaligned(tsize, addr[1:0]);
`else
    live_err = !in_range;
`endif
  end

  // The zero-wait path hits the array on the capture edge itself, so it uses
  // the live request; longer transfers use the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      req_ttype = ttype;
      req_tsize = tsize;
      req_lo    = addr[1:0];
      req_err   = live_err;
      req_idx   = offset[AW+1:2];
      req_wdata = wdata;
    end else begin
      req_ttype = ttype_q;
      req_tsize = tsize_q;
      req_lo    = lo_q;
      req_err   = err_q;
      req_idx   = idx_q;
      req_wdata = wdata_q;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are only meaningful after a capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bstart) begin
      ttype_q <= ttype;
      tsize_q <= tsize;
      lo_q    <= addr[1:0];
      err_q   <= live_err;
      idx_q   <= offset[AW+1:2];
      wdata_q <= wdata;
    end
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bstart) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array access happens once, on the edge entering RESP; reset blocks it.
  always_comb begin
    enter_resp = rst_n && (state_d == RESP);
    mem_we     = enter_resp && (req_ttype == WRITE) && !req_err;
    mem_re     = enter_resp && (req_ttype == READ) && !req_err;
    mem_be     = lane_mask(req_tsize, req_lo);
    mem_wdata  = lane_wdata(req_tsize, req_wdata);
  end

  sram_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (req_idx),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    rd_fmt  = err_q ? 32'h0 : lane_rdata(tsize_q, lo_q, mem_rdata);
    rdata_d = rdata_q;
    if (state_q == RESP && ttype_q == READ) rdata_d = rd_fmt;
  end

  always_comb begin
    bdone = (state_q == RESP);
    rdata = rdata_d;
`ifdef SRAM_SLAVE_ERR_EN
    berr  = (state_q == RESP) && err_q;
`endif
  end

endmodule

// File: doc/sram_slave.md
SRAM_SLAVE -- requirements
Module: sram_slave

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the memory array (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (aligned to DEPTH_WORDS*4).
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning the number of extra cycles inserted before the response.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port bstart, input, 1 bit: the master requests a transfer.
REQ-007 The block SHALL have port ttype, input, ttype_e: READ or WRITE.
REQ-008 The block SHALL have port tsize, input, tsize_e: BYTE, HALF or WORD.
REQ-009 The block SHALL have port addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits: write data, right-justified.
REQ-011 The block SHALL have port rdata, output, 32 bits: read data, right-justified and zero-filled above tsize.
REQ-012 The block SHALL have port bdone, output, 1 bit: a one-cycle pulse marking transfer completion.
REQ-013 The block SHALL have port berr, output, 1 bit: error flag, valid only with bdone (present only under SRAM_SLAVE_ERR_EN).

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-015 IDLE SHALL move to WAIT when bstart=1 and WAIT_STATES>0, or to RESP when bstart=1 and WAIT_STATES=0; IDLE SHALL hold otherwise.
REQ-016 WAIT SHALL load a counter with WAIT_STATES-1 on entry, decrement it each cycle, and move to RESP when the counter reaches 0.
REQ-017 RESP SHALL assert bdone=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-018 The block SHALL capture addr, ttype, tsize and wdata on the edge that leaves IDLE; later changes to these inputs SHALL be ignored until the next transfer.
REQ-019 Latency SHALL be 1+WAIT_STATES cycles from the bstart-sampling edge to the bdone cycle.
REQ-020 A bstart held continuously SHALL start back-to-back transfers, one every 2+WAIT_STATES cycles.
REQ-021 The word index SHALL be (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-022 The lane SHALL be selected by addr[1:0] for BYTE and by addr[1] for HALF; WORD SHALL use the full word.
REQ-023 A READ SHALL return in rdata, during the RESP cycle, the selected byte or half shifted to bit 0 with zeros above; rdata SHALL then hold until the next RESP.
REQ-024 A WRITE SHALL update only the selected byte lanes, taking data from wdata[7:0], wdata[15:0] or wdata[31:0], on the edge entering RESP.
REQ-025 For an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), a READ SHALL return 0 and a WRITE SHALL be dropped; bdone SHALL still pulse.
REQ-026 An invalid tsize encoding (3) SHALL be treated as WORD.

Reset
REQ-027 On rst_n=0, the block SHALL set state=IDLE, bdone=0, rdata=0 and berr=0.
REQ-028 The memory array SHALL NOT be reset.
REQ-029 A reset asserted during WAIT SHALL abort the transfer with no write performed and no bdone.

Configuration
REQ-030 With SRAM_SLAVE_ERR_EN defined, berr SHALL be 1 in the RESP cycle for an out-of-range address, a HALF access with addr[0]=1, or a WORD access with addr[1:0]!=0; an errored WRITE SHALL be dropped and an errored READ SHALL return 0.
REQ-031 With SRAM_SLAVE_ERR_EN undefined, the berr port SHALL be absent and misaligned low address bits SHALL be ignored as in REQ-022.

Structure
REQ-032 Package bus_pkg SHALL hold ttype_e {READ=0, WRITE=1} and tsize_e {BYTE=0, HALF=1, WORD=2}, encoded as load/store funct3[1:0].
REQ-033 Sub-module sram_byte_array SHALL provide the DEPTH_WORDS x 32 storage, with a 4-bit byte-enable write port and a synchronous read port.

Verification
REQ-034 With WAIT_STATES=0: WRITE WORD 0xDEADBEEF to @0x10, then READ WORD @0x10 -> bdone one cycle after each request, rdata=0xDEADBEEF.
REQ-035 After REQ-034: WRITE BYTE 0x55 to @0x12, then READ WORD @0x10 -> rdata=0xDE55BEEF; READ BYTE @0x12 -> rdata=0x00000055; READ HALF @0x12 -> rdata=0x0000DE55.
REQ-036 With WAIT_STATES=3 and bstart held high with constant fields -> bdone pulses every 5 cycles and never two cycles in a row.
REQ-037 Changing addr during WAIT -> the response uses the address captured at start.
REQ-038 Assert rst_n=0 during WAIT of a WRITE to @0x20 holding 0x11111111 -> no bdone, and a later READ @0x20 returns 0x11111111.
REQ-039 With SRAM_SLAVE_ERR_EN defined: READ HALF @0x13 -> berr=1, rdata=0; WRITE WORD at BASE_ADDR+4*DEPTH_WORDS -> berr=1 and memory unchanged.
